// File: rtl/rom_scan_reader_if.sv
// Stream interface for rom_scan_reader beats.
// The master drives each entry with its address and last tag; the slave returns ready.
interface rom_scan_reader_if #(
  parameter int DW = 4,
  parameter int AW = 3
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          last;

  modport master (output valid, output data, output addr, output last, input ready);
  modport slave  (input valid, input data, input addr, input last, output ready);
endinterface

// File: rtl/rom_scan_reader.sv
// Snapshots the table entry bus on start and streams a run of entries over a valid/ready port.
// It also keeps a running sum of the entries the consumer has accepted.
//
//   state  | meaning
//   IDLE   | waiting for start; sum holds the last scan's total
//   SCAN   | out_valid high; one entry per accepted beat
//   DONE   | one-cycle done pulse after the final beat
module rom_scan_reader #(
  parameter int DEPTH = 8,
  parameter int DW    = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int SW    = DW + AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH*DW-1:0]   tbl_flat,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic [AW:0]           count,
  input  logic                  abort,
  rom_scan_reader_if.master     out_if,
  output logic                  busy,
  output logic                  done,
  output logic [SW-1:0]         sum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t              state_q, state_d;
  logic [DEPTH*DW-1:0] snap_q, snap_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [AW:0]         rem_q, rem_d;
  logic [SW-1:0]       sum_q, sum_d;

  logic          scanning;
  logic          last_beat;
  logic          beat;
  logic [DW-1:0] cur_data;
  logic [AW:0]   count_clamped;

  assign scanning  = (state_q == S_SCAN);
  assign last_beat = scanning && (rem_q == ONE_C);
  assign beat      = scanning && out_if.ready;
  assign cur_data  = snap_q[ptr_q*DW +: DW];

  // A count of zero or anything past the table size means a full sweep.
  always_comb begin
    count_clamped = count;
    if ((count == '0) || (count > DEPTH_C)) begin
      count_clamped = DEPTH_C;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = tbl_flat;
          ptr_d   = start_addr;
          rem_d   = count_clamped;
          sum_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (beat) begin
          sum_d = sum_q + SW'(cur_data);
          ptr_d = ptr_q + AW'(1);
          rem_d = rem_q - ONE_C;
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
        // The beat still lands in the sum, but abort overrides the advance to DONE.
        if (abort) begin
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
    end
  end

  assign out_if.valid = scanning;
  assign out_if.data  = cur_data;
  assign out_if.addr  = ptr_q;
  assign out_if.last  = last_beat;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;

endmodule

// File: tb/tb_rom_scan_reader.sv
// Directed bench for rom_scan_reader: a queue-based scan model checked every cycle,
// plus literal expectations for each scenario.
module tb_rom_scan_reader;
  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int SW    = DW + AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DEPTH*DW-1:0] tbl_flat;
  logic              start = 1'b0;
  logic [AW-1:0]     start_addr = '0;
  logic [AW:0]       count = '0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;
  logic [SW-1:0]     sum;

  rom_scan_reader_if #(.DW(DW), .AW(AW)) out_if ();
  assign out_if.ready = out_ready;

  rom_scan_reader #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .SW(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tbl_flat   (tbl_flat),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .abort      (abort),
    .out_if     (out_if),
    .busy       (busy),
    .done       (done),
    .sum        (sum)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t m_q[$];
  bit    m_active = 1'b0;
  bit    m_done   = 1'b0;
  int    m_sum    = 0;

  task automatic model_step();
    bit    fin;
    int    n;
    beat_t b;
    fin = 1'b0;
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_sum    = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (out_ready) begin
        m_sum += int'(m_q[0].data);
        void'(m_q.pop_front());
        fin = (m_q.size() == 0);
      end
      if (abort) begin
        m_active = 1'b0;
        m_q.delete();
      end else if (fin) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (start) begin
      n = ((count == 0) || (int'(count) > DEPTH)) ? DEPTH : int'(count);
      m_sum = 0;
      m_q.delete();
      for (int i = 0; i < n; i++) begin
        b.addr = AW'((int'(start_addr) + i) % DEPTH);
        b.data = tbl_flat[int'(b.addr)*DW +: DW];
        m_q.push_back(b);
      end
      m_active = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // ---------------- per-cycle compare and beat log ----------------
  typedef struct packed {
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } log_t;

  log_t log_q[$];
  int   done_cnt = 0;

  initial begin
    log_t e;
    forever begin
      @(negedge clk);
      chk("valid", out_if.valid, m_active);
      chk("busy", busy, m_active || m_done);
      chk("done", done, m_done);
      chk("sum", sum, m_sum);
      if (m_active) begin
        chk("data", out_if.data, m_q[0].data);
        chk("addr", out_if.addr, m_q[0].addr);
        chk("last", out_if.last, m_q.size() == 1);
      end
      if (rst_n && out_if.valid && out_ready) begin
        e.last = out_if.last;
        e.addr = out_if.addr;
        e.data = out_if.data;
        log_q.push_back(e);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int exp_d[8];
  int exp_a[8];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_start(input int sa, input int cnt);
    start_addr = AW'(sa);
    count      = (AW+1)'(cnt);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((m_active || m_done) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic clear_log();
    log_q.delete();
    done_cnt = 0;
  endtask

  task automatic chk_beats(input string nm, input int n);
    chk({nm, "_beats"}, log_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < log_q.size()) begin
        chk({nm, "_data"}, log_q[i].data, exp_d[i]);
        chk({nm, "_addr"}, log_q[i].addr, exp_a[i]);
        chk({nm, "_last"}, log_q[i].last, (i == n - 1) ? 1 : 0);
      end
    end
  endtask

  task automatic set_tbl();
    for (int k = 0; k < DEPTH; k++) tbl_flat[k*DW +: DW] = DW'(2 * k);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    set_tbl();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", out_if.valid, 0);
    chk("rst_last", out_if.last, 0);
    chk("rst_data", out_if.data, 0);
    chk("rst_addr", out_if.addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    rst_n = 1'b1;
    tick();

    // T1: wrap-around run of four
    clear_log();
    run_start(6, 4);
    wait_idle("t1");
    exp_d[0:3] = '{12, 14, 0, 2};
    exp_a[0:3] = '{6, 7, 0, 1};
    chk_beats("t1", 4);
    chk("t1_sum", sum, 28);
    chk("t1_done_pulses", done_cnt, 1);

    // abort while idle must be ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_sum", sum, 28);

    // T2: count 0 means the whole table
    clear_log();
    run_start(0, 0);
    chk("t2_first_valid", out_if.valid, 1);
    wait_idle("t2");
    exp_d = '{0, 2, 4, 6, 8, 10, 12, 14};
    exp_a = '{0, 1, 2, 3, 4, 5, 6, 7};
    chk_beats("t2", 8);
    chk("t2_sum", sum, 56);

    // T3: back-pressure with ready 1,0,0,1,...
    clear_log();
    run_start(0, 3);
    for (int i = 0; i < 100 && m_active; i++) begin
      out_ready = ((i % 4) == 0 || (i % 4) == 3);
      tick();
    end
    out_ready = 1'b1;
    wait_idle("t3");
    exp_d[0:2] = '{0, 2, 4};
    exp_a[0:2] = '{0, 1, 2};
    chk_beats("t3", 3);
    chk("t3_sum", sum, 6);

    // T4: abort coincident with the second beat
    clear_log();
    run_start(0, 5);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_valid", out_if.valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_sum", sum, 2);
    repeat (3) tick();
    chk("t4_done_pulses", done_cnt, 0);
    chk("t4_beats", log_q.size(), 2);

    // T5: start while busy and table change mid-scan
    clear_log();
    out_ready = 1'b0;
    run_start(2, 4);
    tick();
    tbl_flat   = '1;
    start_addr = 3'd0;
    count      = 4'd1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    out_ready  = 1'b1;
    wait_idle("t5");
    set_tbl();
    exp_d[0:3] = '{4, 6, 8, 10};
    exp_a[0:3] = '{2, 3, 4, 5};
    chk_beats("t5", 4);
    chk("t5_sum", sum, 28);
    tick();
    chk("t5_no_requeue", busy, 0);

    // count beyond table size clamps to a full sweep
    clear_log();
    run_start(5, 12);
    wait_idle("t7");
    exp_d = '{10, 12, 14, 0, 2, 4, 6, 8};
    exp_a = '{5, 6, 7, 0, 1, 2, 3, 4};
    chk_beats("t7", 8);
    chk("t7_sum", sum, 56);

    // single-entry scan at the top index
    clear_log();
    run_start(7, 1);
    wait_idle("t8");
    exp_d[0] = 14;
    exp_a[0] = 7;
    chk_beats("t8", 1);
    chk("t8_sum", sum, 14);
    chk("t8_done_pulses", done_cnt, 1);

    // T6: asynchronous reset in the middle of a scan
    clear_log();
    run_start(0, 8);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid", out_if.valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_sum", sum, 0);
    chk("t6_data", out_if.data, 0);
    chk("t6_addr", out_if.addr, 0);
    chk("t6_last", out_if.last, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_no_partial_done", done_cnt, 0);
    clear_log();
    run_start(3, 2);
    wait_idle("t6b");
    exp_d[0:1] = '{6, 8};
    exp_a[0:1] = '{3, 4};
    chk_beats("t6b", 2);
    chk("t6b_sum", sum, 14);
    chk("t6b_done_pulses", done_cnt, 1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
